// File: rtl/apb_master_bridge.sv
// APB3 requester: valid/ready command in, one SETUP+ACCESS transfer out, one response pulse back.
// Optional macro APB_MASTER_TIMEOUT_EN aborts ACCESS after TIMEOUT_CYCLES wait states.
module apb_master_bridge #(
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              accept;
  logic              timeout_hit;

  assign accept = cmd_valid && (state_q == ST_IDLE);

`ifdef APB_MASTER_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] wait_cnt_q, wait_cnt_d;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_q == ST_SETUP) begin
      wait_cnt_d = 8'd0;
    end else if (state_q == ST_ACCESS && !PREADY) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end
  end

  // Abort on the edge where this wait cycle would bring the count to the limit.
  assign timeout_hit = (state_q == ST_ACCESS) && !PREADY && (wait_cnt_q == TO_LAST);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wait_cnt_q <= 8'd0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d  = ST_SETUP;
          psel_d   = 1'b1;
          pwrite_d = cmd_write;
          paddr_d  = cmd_addr;
          if (cmd_write) begin
            pwdata_d = cmd_wdata;
          end
        end
      end
      ST_SETUP: begin
        state_d   = ST_ACCESS;
        penable_d = 1'b1;
      end
      ST_ACCESS: begin
        // PREADY wins over a timeout landing on the same edge.
        if (PREADY) begin
          state_d     = ST_IDLE;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = PSLVERR;
          if (!pwrite_q) begin
            rsp_rdata_d = PRDATA;
          end
        end else if (timeout_hit) begin
          state_d     = ST_IDLE;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= ST_IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Randomized bench for apb_master_bridge against a transfer-level model with a memory-backed APB slave.
module tb_apb_master_bridge;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [7:0]  PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  apb_master_bridge #(
    .ADDR_W(8),
    .DATA_W(32),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .PCLK(PCLK),
    .PRESETn(PRESETn),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .PSEL(PSEL),
    .PENABLE(PENABLE),
    .PWRITE(PWRITE),
    .PADDR(PADDR),
    .PWDATA(PWDATA),
    .PRDATA(PRDATA),
    .PREADY(PREADY),
    .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  int cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] mem [256];
  logic [31:0] exp_pwdata;
  logic [31:0] exp_rdata;
  int          last_setup;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  // One full transfer; spacing < 0 skips the SETUP-to-SETUP distance check.
  task automatic do_xfer(input bit wr, input logic [7:0] addr, input logic [31:0] wdata,
                         input int waits, input bit err, input bit chain, input int spacing);
    int setup_c;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    check("cmd_ready_idle", cmd_ready, 1);
    step();
    // Garbage on the command bus must be ignored while busy.
    cmd_valid = 1'($urandom_range(0, 1));
    cmd_write = 1'($urandom);
    cmd_addr  = 8'($urandom);
    cmd_wdata = $urandom;
    if (wr) exp_pwdata = wdata;
    setup_c = cyc;
    if (spacing >= 0) check("setup_spacing", 32'(setup_c - last_setup), 32'(spacing));
    last_setup = setup_c;
    check("setup_psel", PSEL, 1);
    check("setup_penable", PENABLE, 0);
    check("setup_paddr", PADDR, addr);
    check("setup_pwrite", PWRITE, wr);
    check("setup_pwdata", PWDATA, exp_pwdata);
    check("setup_cmd_ready", cmd_ready, 0);
    step();
    for (int i = 0; i <= waits; i++) begin
      check("access_psel", PSEL, 1);
      check("access_penable", PENABLE, 1);
      check("access_paddr", PADDR, addr);
      check("access_pwdata", PWDATA, exp_pwdata);
      check("access_no_rsp", rsp_valid, 0);
      PREADY  = (i == waits);
      PSLVERR = (i == waits) ? err : 1'($urandom);
      PRDATA  = (i == waits && !wr) ? mem[addr] : $urandom;
      step();
    end
    PREADY  = 1'b0;
    PSLVERR = 1'b0;
    if (!wr) exp_rdata = mem[addr];
    if (wr && !err) mem[addr] = wdata;
    check("rsp_valid", rsp_valid, 1);
    check("rsp_err", rsp_err, err);
    check("rsp_rdata", rsp_rdata, exp_rdata);
    check("rsp_psel", PSEL, 0);
    check("rsp_penable", PENABLE, 0);
    check("rsp_cmd_ready", cmd_ready, 1);
    check("rsp_paddr_hold", PADDR, addr);
    $display("xfer wr=%0d addr=0x%02h wdata=0x%08h waits=%0d err=%0d chain=%0d rdata=0x%08h",
             wr, addr, wdata, waits, err, chain, rsp_rdata);
    cmd_valid = 1'b0;
    if (!chain) begin
      step();
      check("rsp_single_pulse", rsp_valid, 0);
    end
  endtask

  initial begin
    int w, pw;
    bit pc, wr, er;
    int rsp_seen;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    PRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
    exp_pwdata = '0; exp_rdata = '0; last_setup = 0;
    repeat (3) step();
    check("rst_psel", PSEL, 0);
    check("rst_penable", PENABLE, 0);
    check("rst_paddr", PADDR, 0);
    check("rst_pwdata", PWDATA, 0);
    check("rst_pwrite", PWRITE, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    PRESETn = 1'b1;
    step();

    // Directed: zero-wait write, 3-wait read, back-to-back, slave error.
    do_xfer(1'b1, 8'h10, 32'hDEADBEEF, 0, 1'b0, 1'b0, -1);
    mem[8'h20] = 32'hCAFEF00D;
    do_xfer(1'b0, 8'h20, 32'h0, 3, 1'b0, 1'b0, -1);
    do_xfer(1'b1, 8'h04, 32'h12345678, 0, 1'b0, 1'b1, -1);
    do_xfer(1'b0, 8'h04, 32'h0, 0, 1'b0, 1'b0, 3);
    do_xfer(1'b1, 8'h30, 32'hA5A5A5A5, 1, 1'b1, 1'b0, -1);
    do_xfer(1'b0, 8'h30, 32'h0, 0, 1'b0, 1'b0, -1);

    // Random transfers; chained ones must start SETUP exactly 3+waits cycles later.
    pc = 1'b0; pw = 0;
    for (int n = 0; n < 40; n++) begin
      w  = $urandom_range(0, 2);
      wr = 1'($urandom);
      er = ($urandom_range(0, 7) == 0);
      do_xfer(wr, 8'($urandom_range(0, 15)), $urandom, w, er, 1'($urandom), pc ? 3 + pw : -1);
      pc = (cmd_valid == 1'b0) && rsp_valid;
      pw = w;
    end
    if (pc) step();

    // Reset while stalled in ACCESS: PSEL/PENABLE must drop before any clock edge.
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h55; cmd_wdata = 32'h0BADF00D;
    step();
    cmd_valid = 1'b0;
    step();
    check("pre_rst_penable", PENABLE, 1);
    #2 PRESETn = 1'b0;
    #1;
    check("async_rst_psel", PSEL, 0);
    check("async_rst_penable", PENABLE, 0);
    check("async_rst_rsp", rsp_valid, 0);
    step();
    PRESETn = 1'b1;
    exp_pwdata = '0; exp_rdata = '0;
    step();
    check("post_rst_cmd_ready", cmd_ready, 1);
    check("post_rst_no_rsp", rsp_valid, 0);
    check("post_rst_pwdata", PWDATA, 0);
    $display("xfer reset-in-access addr=0x55 dropped");

`ifdef APB_MASTER_TIMEOUT_EN
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h44;
    step();
    cmd_valid = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      check("to_wait_penable", PENABLE, 1);
      check("to_wait_no_rsp", rsp_valid, 0);
      PREADY = 1'b0;
      step();
    end
    check("to_rsp_valid", rsp_valid, 1);
    check("to_rsp_err", rsp_err, 1);
    check("to_rsp_rdata", rsp_rdata, 0);
    check("to_psel", PSEL, 0);
    exp_rdata = '0;
    $display("xfer timeout addr=0x44 err=%0d rdata=0x%08h", rsp_err, rsp_rdata);
    step();
    check("to_single_pulse", rsp_valid, 0);
`else
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h44;
    step();
    cmd_valid = 1'b0;
    step();
    rsp_seen = 0;
    for (int i = 0; i < 30; i++) begin
      if (rsp_valid || !PENABLE || !PSEL) rsp_seen++;
      step();
    end
    check("no_timeout_stall", 32'(rsp_seen), 0);
    PREADY = 1'b1; PRDATA = mem[8'h44];
    step();
    PREADY = 1'b0;
    exp_rdata = mem[8'h44];
    check("late_rsp_valid", rsp_valid, 1);
    check("late_rsp_err", rsp_err, 0);
    check("late_rsp_rdata", rsp_rdata, exp_rdata);
    $display("xfer long-stall addr=0x44 rdata=0x%08h", rsp_rdata);
    step();
`endif

    do_xfer(1'b0, 8'h10, 32'h0, 0, 1'b0, 1'b0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
